// File: rtl/adc_channel_scheduler.sv
// Two-channel ADC averaging scheduler: 1/4/16/64-sample averages per enabled channel,
// round-robin into one FIFO write port. Define CHANNEL_TAG_EN to tag out_data[15:13].
//
// state | meaning
// IDLE  | waiting for an eligible pending result and a non-full FIFO
// WRITE | write strobe high for this cycle, then back to IDLE
module adc_channel_scheduler #(
  parameter int ADC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           channel_select,
  input  logic [1:0]           average_points,
  input  logic                 rst_fifo,
  input  logic [ADC_WIDTH-1:0] ch1_data,
  input  logic                 ch1_valid,
  input  logic [ADC_WIDTH-1:0] ch2_data,
  input  logic                 ch2_valid,
  input  logic                 out_full,
  output logic [15:0]          out_data,
  output logic                 out_wr_en,
  output logic                 overflow
);

  localparam int AW = ADC_WIDTH + 6;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [AW-1:0]        acc_q [2];
  logic [AW-1:0]        acc_d [2];
  logic [5:0]           cnt_q [2];
  logic [5:0]           cnt_d [2];
  logic [15:0]          res_q [2];
  logic [15:0]          res_d [2];
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           avg_prev_q, avg_prev_d;
  logic                 avg_seen_q, avg_seen_d;
  logic [0:0]           state_q, state_d;
  logic                 last_ch_q, last_ch_d;
  logic [15:0]          out_data_q, out_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 ovf_q, ovf_d;

  logic [ADC_WIDTH-1:0] din [2];
  logic [1:0]           vin;
  logic [AW-1:0]        sum [2];
  logic [15:0]          new_word [2];
  logic [5:0]           last_cnt;
  logic [2:0]           shift;
  logic                 avg_change;
  logic [1:0]           pend_elig;
  logic                 grant_any;
  logic                 grant_ch;
  logic [1:0]           drain;
  logic [1:0]           drop;

  assign din[0] = ch1_data;
  assign din[1] = ch2_data;
  assign vin    = {ch2_valid, ch1_valid};

  always_comb begin
    last_cnt = 6'd0;
    shift    = 3'd0;
    case (average_points)
      2'b01:   begin last_cnt = 6'd3;  shift = 3'd2; end
      2'b10:   begin last_cnt = 6'd15; shift = 3'd4; end
      2'b11:   begin last_cnt = 6'd63; shift = 3'd6; end
      default: begin last_cnt = 6'd0;  shift = 3'd0; end
    endcase
  end

  // avg_seen_q masks the first cycle after async reset so a stale avg_prev_q
  // cannot fake a code change and throw away the first sample.
  assign avg_change = avg_seen_q && (average_points != avg_prev_q);
  assign avg_prev_d = average_points;
  assign avg_seen_d = 1'b1;

  assign pend_elig = pend_q & channel_select;
  assign grant_any = (state_q == S_IDLE) && !out_full && (pend_elig != 2'b00);
  assign grant_ch  = (pend_elig == 2'b11) ? ~last_ch_q : pend_elig[1];
  assign drain     = grant_any ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sum[i] = acc_q[i] + AW'(din[i]);
      new_word[i] = '0;
      new_word[i][ADC_WIDTH-1:0] = ADC_WIDTH'(sum[i] >> shift);
`ifdef CHANNEL_TAG_EN
      new_word[i][15]    = (i == 1);
      new_word[i][14:13] = average_points;
`endif
    end
  end

  always_comb begin
    drop   = 2'b00;
    pend_d = pend_q & ~drain;
    for (int i = 0; i < 2; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = cnt_q[i];
      res_d[i] = res_q[i];
      if (rst_fifo || !channel_select[i]) begin
        acc_d[i]  = '0;
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
      end else if (avg_change) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end else if (vin[i]) begin
        if (cnt_q[i] >= last_cnt) begin
          acc_d[i] = '0;
          cnt_d[i] = '0;
          // pend_d already reflects a same-edge drain, so a drained slot accepts the new word
          if (pend_d[i]) begin
            drop[i] = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
            res_d[i]  = new_word[i];
          end
        end else begin
          acc_d[i] = sum[i];
          cnt_d[i] = cnt_q[i] + 6'd1;
        end
      end
    end
  end

  assign ovf_d = rst_fifo ? 1'b0 : (ovf_q | (|drop));

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    out_data_d = out_data_q;
    last_ch_d  = last_ch_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d    = S_WRITE;
          wr_en_d    = 1'b1;
          out_data_d = res_q[grant_ch];
          last_ch_d  = grant_ch;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_fifo) begin
      state_d    = S_IDLE;
      wr_en_d    = 1'b0;
      out_data_d = '0;
      last_ch_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        res_q[i] <= '0;
      end
      pend_q     <= '0;
      avg_prev_q <= '0;
      avg_seen_q <= 1'b0;
      state_q    <= S_IDLE;
      last_ch_q  <= 1'b1;
      out_data_q <= '0;
      wr_en_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
        res_q[i] <= res_d[i];
      end
      pend_q     <= pend_d;
      avg_prev_q <= avg_prev_d;
      avg_seen_q <= avg_seen_d;
      state_q    <= state_d;
      last_ch_q  <= last_ch_d;
      out_data_q <= out_data_d;
      wr_en_q    <= wr_en_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_wr_en = wr_en_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Bench for adc_channel_scheduler: directed vectors, a sample-list averaging model
// compared every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_adc_channel_scheduler;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   channel_select = 2'b00;
  logic [1:0]   average_points = 2'b00;
  logic         rst_fifo = 1'b0;
  logic [W-1:0] ch1_data = '0;
  logic         ch1_valid = 1'b0;
  logic [W-1:0] ch2_data = '0;
  logic         ch2_valid = 1'b0;
  logic         out_full = 1'b0;
  logic [15:0]  out_data;
  logic         out_wr_en;
  logic         overflow;

  adc_channel_scheduler #(.ADC_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .channel_select(channel_select),
    .average_points(average_points), .rst_fifo(rst_fifo),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid),
    .ch2_data(ch2_data), .ch2_valid(ch2_valid),
    .out_full(out_full), .out_data(out_data), .out_wr_en(out_wr_en),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: running sum/count per channel, result = sum/N, one-deep holding slot,
  // a write may launch only when no write happened the cycle before.
  int  m_sum [2];
  int  m_cnt [2];
  int  m_res [2];
  bit  m_pend [2];
  bit  m_ovf, m_wr;
  int  m_data, m_last, m_prev;
  bit  m_seen;
  int  mn, mg, tot, wd;
  bit  chg, e0, e1;
  int  vdat [2];
  bit  vval [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_sum[c] = 0; m_cnt[c] = 0; m_res[c] = 0; m_pend[c] = 0;
      end
      m_ovf = 0; m_wr = 0; m_data = 0; m_last = 1; m_prev = 0; m_seen = 0;
    end else if (rst_fifo) begin
      for (int c = 0; c < 2; c++) begin
        m_sum[c] = 0; m_cnt[c] = 0; m_pend[c] = 0;
      end
      m_ovf = 0; m_wr = 0; m_data = 0; m_last = 1;
      m_prev = int'(average_points); m_seen = 1;
    end else begin
      mn  = 1 << (2 * int'(average_points));
      chg = m_seen && (int'(average_points) != m_prev);
      vdat[0] = int'(ch1_data); vdat[1] = int'(ch2_data);
      vval[0] = ch1_valid;      vval[1] = ch2_valid;
      e0 = m_pend[0] && channel_select[0];
      e1 = m_pend[1] && channel_select[1];
      mg = -1;
      if (!m_wr && !out_full) begin
        if (e0 && e1) mg = (m_last == 0) ? 1 : 0;
        else if (e0)  mg = 0;
        else if (e1)  mg = 1;
      end
      m_wr = 0;
      if (mg >= 0) begin
        m_wr = 1; m_data = m_res[mg]; m_pend[mg] = 0; m_last = mg;
      end
      for (int c = 0; c < 2; c++) begin
        if (!channel_select[c]) begin
          m_sum[c] = 0; m_cnt[c] = 0; m_pend[c] = 0;
        end else if (chg) begin
          m_sum[c] = 0; m_cnt[c] = 0;
        end else if (vval[c]) begin
          m_sum[c] += vdat[c];
          m_cnt[c] += 1;
          if (m_cnt[c] == mn) begin
            tot = m_sum[c];
            m_sum[c] = 0; m_cnt[c] = 0;
            if (m_pend[c]) m_ovf = 1;
            else begin
              wd = tot / mn;
`ifdef CHANNEL_TAG_EN
              wd = wd | (c << 15) | (int'(average_points) << 13);
`endif
              m_pend[c] = 1; m_res[c] = wd;
            end
          end
        end
      end
      m_prev = int'(average_points); m_seen = 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("wr_en", out_wr_en, m_wr);
      if (m_wr) chk("out_data", out_data, m_data);
      chk("overflow", overflow, m_ovf);
    end
  end

  typedef struct { int data; int cyc; } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (reset_n && out_wr_en) wq.push_back('{int'(out_data), cyc});

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input bit v1, input int d1, input bit v2, input int d2, output int sc);
    @(negedge clk);
    ch1_valid = v1; ch1_data = W'(d1);
    ch2_valid = v2; ch2_data = W'(d2);
    sc = cyc;
    @(negedge clk);
    ch1_valid = 1'b0; ch2_valid = 1'b0;
  endtask

  int s1, s2, sd;

  initial begin
    idle(3);
    reset_n = 1'b1;
    chk("reset_out_data", out_data, 0);
    chk("reset_wr_en", out_wr_en, 0);
    chk("reset_overflow", overflow, 0);

    // single-sample pass-through on ch1
    channel_select = 2'b01; average_points = 2'b00;
    idle(2); wq.delete();
    sample(1, 'h123, 0, 0, s1); idle(2);
    sample(1, 'h456, 0, 0, s2); idle(6);
    chk("t1_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t1_w0", wq[0].data & 'hFFF, 'h123);
      chk("t1_w1", wq[1].data & 'hFFF, 'h456);
      chk("t1_lat0", wq[0].cyc - s1, 2);
      chk("t1_lat1", wq[1].cyc - s2, 2);
      chk("t1_tag", (wq[0].data >> 15) & 1, 0);
    end

    // 4-point averages on both channels, ch1 first after pointer reset
    @(negedge clk);
    channel_select = 2'b11; average_points = 2'b01; rst_fifo = 1'b1;
    @(negedge clk); rst_fifo = 1'b0;
    idle(2); wq.delete();
    for (int k = 1; k <= 4; k++) sample(1, 10 * k, 1, 10 * k, sd);
    idle(6);
    chk("t2_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t2_w0", wq[0].data & 'hFFF, 25);
      chk("t2_w1", wq[1].data & 'hFFF, 25);
      chk("t2_gap", wq[1].cyc - wq[0].cyc, 2);
`ifdef CHANNEL_TAG_EN
      chk("t2_ch_order", {(wq[0].data >> 15) & 1, (wq[1].data >> 15) & 1}, 32'h1);
`endif
    end
    chk("t2_overflow", overflow, 0);

    // full held: second result dropped, first kept
    @(negedge clk);
    out_full = 1'b1; channel_select = 2'b01; average_points = 2'b00;
    idle(2); wq.delete();
    sample(1, 5, 0, 0, sd);
    sample(1, 6, 0, 0, sd);
    idle(3);
    chk("t3_no_write", wq.size(), 0);
    chk("t3_overflow", overflow, 1);
    @(negedge clk); out_full = 1'b0;
    idle(5);
    chk("t3_count", wq.size(), 1);
    if (wq.size() == 1) chk("t3_w0", wq[0].data & 'hFFF, 5);

    // clear pulse drops pendings and overflow and resets the pointer to ch1
    @(negedge clk); out_full = 1'b1; channel_select = 2'b11;
    idle(2); wq.delete();
    sample(1, 7, 1, 8, sd);
    sample(1, 9, 1, 9, sd);
    idle(1);
    chk("t5_overflow_set", overflow, 1);
    @(negedge clk); rst_fifo = 1'b1;
    @(negedge clk); rst_fifo = 1'b0;
    chk("t5_overflow_clr", overflow, 0);
    chk("t5_out_data_clr", out_data, 0);
    @(negedge clk); out_full = 1'b0;
    idle(5);
    chk("t5_no_write", wq.size(), 0);
    sample(1, 'h11, 1, 'h22, sd);
    idle(6);
    chk("t5_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t5_w0", wq[0].data & 'hFFF, 'h11);
      chk("t5_w1", wq[1].data & 'hFFF, 'h22);
    end

    // 64-point full-scale, then an average code change mid-accumulation
    @(negedge clk); channel_select = 2'b01; average_points = 2'b11;
    idle(2); wq.delete();
    repeat (64) sample(1, 'hFFF, 0, 0, sd);
    idle(4);
    chk("t4_count64", wq.size(), 1);
    if (wq.size() == 1) chk("t4_full_scale", wq[0].data & 'hFFF, 'hFFF);
    wq.delete();
    repeat (30) sample(1, 'h100, 0, 0, sd);
    @(negedge clk); average_points = 2'b10;
    @(negedge clk); average_points = 2'b11;
    idle(1);
    repeat (63) sample(1, 'h200, 0, 0, sd);
    idle(4);
    chk("t4_no_early", wq.size(), 0);
    sample(1, 'h200, 0, 0, sd);
    idle(4);
    chk("t4_restart_count", wq.size(), 1);
    if (wq.size() == 1) chk("t4_restart_val", wq[0].data & 'hFFF, 'h200);

    // async reset during the write cycle
    @(negedge clk); average_points = 2'b00;
    idle(2); wq.delete();
    sample(1, 'h3AB, 0, 0, sd);
    @(posedge clk); #2;
    chk("t6_wr_mid", out_wr_en, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_wr_async", out_wr_en, 0);
    chk("t6_data_async", out_data, 0);
    chk("t6_ovf_async", overflow, 0);
    idle(2);
    reset_n = 1'b1;
    idle(8);
    chk("t6_quiet", wq.size(), 0);
    sample(1, 'h0AB, 0, 0, sd);
    idle(4);
    chk("t6_count", wq.size(), 1);
    if (wq.size() == 1) chk("t6_w0", wq[0].data & 'hFFF, 'h0AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
